// File: rtl/dot_matrix_animator.sv
// Row-scanning LED dot-matrix driver with a host-writable multi-frame pattern buffer
// and timed frame animation (SCANS full scans per frame, wrap at last_frame).
module dot_matrix_animator #(
  parameter int ROWS   = 10,
  parameter int COLS   = 14,
  parameter int FRAMES = 10,
  parameter int DIV    = 12500,
  parameter int SCANS  = 64,
  localparam int FW    = (FRAMES > 1) ? $clog2(FRAMES) : 1,
  localparam int RW    = $clog2(ROWS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            pause,
  input  logic [FW-1:0]   last_frame,
  input  logic            wr_en,
  input  logic [FW-1:0]   wr_frame,
  input  logic [RW-1:0]   wr_row,
  input  logic [COLS-1:0] wr_data,
  output logic [ROWS-1:0] dot_row,
  output logic [COLS-1:0] dot_col,
  output logic [FW-1:0]   frame_idx,
  output logic            frame_start
);

  localparam int PW = $clog2(DIV);
  localparam int SW = (SCANS > 1) ? $clog2(SCANS) : 1;
  localparam int AW = $clog2(FRAMES * ROWS);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [RW-1:0]   row_idx_q, row_idx_d;
  logic [SW-1:0]   scan_cnt_q, scan_cnt_d;
  logic [FW-1:0]   frame_idx_q, frame_idx_d;
  logic [ROWS-1:0] dot_row_q, dot_row_d;
  logic [COLS-1:0] dot_col_q, dot_col_d;
  logic            frame_start_q, frame_start_d;
  logic            start_pend_q, start_pend_d;

  logic [COLS-1:0] pat_mem [FRAMES*ROWS];
  logic [AW-1:0]   rd_addr, wr_addr;
  logic            wr_ok;
  logic [FW-1:0]   last_eff;
  logic            tick;

  // Pattern buffer: flat frame-major storage, out-of-range writes dropped.
  always_comb begin
    wr_ok   = wr_en && (int'(wr_frame) < FRAMES) && (int'(wr_row) < ROWS);
    wr_addr = AW'(int'(wr_frame) * ROWS + int'(wr_row));
    rd_addr = AW'(int'(frame_idx_q) * ROWS + int'(row_idx_q));
  end

  always_ff @(posedge clk) begin
    if (wr_ok) pat_mem[wr_addr] <= wr_data;
  end

  always_comb begin
    state_d       = state_q;
    presc_d       = presc_q;
    row_idx_d     = row_idx_q;
    scan_cnt_d    = scan_cnt_q;
    frame_idx_d   = frame_idx_q;
    dot_row_d     = dot_row_q;
    dot_col_d     = dot_col_q;
    start_pend_d  = start_pend_q;
    frame_start_d = 1'b0;

    if (int'(last_frame) > FRAMES - 1) last_eff = FW'(FRAMES - 1);
    else                               last_eff = last_frame;

    tick = (state_q == SCAN) && (presc_q == PW'(DIV - 1));

    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = SCAN;
          presc_d = '0;
        end
      end
      default: begin
        if (!en) begin
          state_d      = IDLE;
          presc_d      = '0;
          row_idx_d    = '0;
          scan_cnt_d   = '0;
          dot_row_d    = '0;
          dot_col_d    = '0;
          start_pend_d = 1'b0;
        end else begin
          presc_d = tick ? '0 : presc_q + PW'(1);
          if (tick) begin
            // Read sees pre-write contents, so a same-cycle write shows next scan.
            dot_row_d     = ROWS'(1) << row_idx_q;
            dot_col_d     = pat_mem[rd_addr];
            frame_start_d = start_pend_q;
            start_pend_d  = 1'b0;
            if (row_idx_q == RW'(ROWS - 1)) begin
              row_idx_d = '0;
              if (scan_cnt_q == SW'(SCANS - 1)) begin
                scan_cnt_d = '0;
                if (!pause) begin
                  frame_idx_d  = (frame_idx_q >= last_eff) ? '0 : frame_idx_q + FW'(1);
                  start_pend_d = 1'b1;
                end
              end else begin
                scan_cnt_d = scan_cnt_q + SW'(1);
              end
            end else begin
              row_idx_d = row_idx_q + RW'(1);
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      presc_q       <= '0;
      row_idx_q     <= '0;
      scan_cnt_q    <= '0;
      frame_idx_q   <= '0;
      dot_row_q     <= '0;
      dot_col_q     <= '0;
      frame_start_q <= 1'b0;
      start_pend_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      row_idx_q     <= row_idx_d;
      scan_cnt_q    <= scan_cnt_d;
      frame_idx_q   <= frame_idx_d;
      dot_row_q     <= dot_row_d;
      dot_col_q     <= dot_col_d;
      frame_start_q <= frame_start_d;
      start_pend_q  <= start_pend_d;
    end
  end

  assign dot_row     = dot_row_q;
  assign dot_col     = dot_col_q;
  assign frame_idx   = frame_idx_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_dot_matrix_animator.sv
// Directed bench for dot_matrix_animator: 3x4 matrix, 2 frames, 4-clk rows, 2 scans/frame.
module tb_dot_matrix_animator;

  logic       clk = 1'b0;
  logic       rst, en, pause, wr_en;
  logic [0:0] last_frame, wr_frame;
  logic [1:0] wr_row;
  logic [3:0] wr_data;
  logic [2:0] dot_row;
  logic [3:0] dot_col;
  logic [0:0] frame_idx;
  logic       frame_start;

  int nassert = 0;
  int nfail   = 0;

  typedef struct packed {
    logic [2:0] row;
    logic [3:0] col;
    logic       fidx;
    logic       fs;
  } exp_t;
  exp_t sb[$];

  dot_matrix_animator #(.ROWS(3), .COLS(4), .FRAMES(2), .DIV(4), .SCANS(2)) dut (
    .clk(clk), .rst(rst), .en(en), .pause(pause), .last_frame(last_frame),
    .wr_en(wr_en), .wr_frame(wr_frame), .wr_row(wr_row), .wr_data(wr_data),
    .dot_row(dot_row), .dot_col(dot_col), .frame_idx(frame_idx), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] r, input logic [3:0] c, input logic f, input logic s);
    exp_t e;
    e.row = r; e.col = c; e.fidx = f; e.fs = s;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("dot_row", 32'(dot_row), 32'(e.row));
      check("dot_col", 32'(dot_col), 32'(e.col));
      check("frame_idx", 32'(frame_idx), 32'(e.fidx));
      check("frame_start", 32'(frame_start), 32'(e.fs));
    end
  endtask

  task automatic run_ticks(input int first_gap);
    cyc(first_gap);
    pop_check();
    while (sb.size() != 0) begin
      cyc(4);
      pop_check();
    end
  endtask

  task automatic wr(input logic f, input logic [1:0] r, input logic [3:0] d);
    wr_en = 1'b1; wr_frame = f; wr_row = r; wr_data = d;
    cyc(1);
    wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; pause = 1'b0; last_frame = 1'b0;
    wr_en = 1'b0; wr_frame = 1'b0; wr_row = 2'd0; wr_data = 4'h0;
    cyc(2);
    check("reset_dot_row", 32'(dot_row), 32'h0);
    check("reset_dot_col", 32'(dot_col), 32'h0);
    check("reset_frame_idx", 32'(frame_idx), 32'h0);
    check("reset_frame_start", 32'(frame_start), 32'h0);
    rst = 1'b0;
    cyc(1);

    wr(1'b0, 2'd0, 4'h1); wr(1'b0, 2'd1, 4'h2); wr(1'b0, 2'd2, 4'h4);
    wr(1'b1, 2'd0, 4'h8); wr(1'b1, 2'd1, 4'h9); wr(1'b1, 2'd2, 4'hA);
    wr(1'b0, 2'd3, 4'hF);
    check("idle_blank", 32'(dot_row), 32'h0);

    // Two scans of frame 0, two of frame 1, wrap back to frame 0.
    last_frame = 1'b1;
    en = 1'b1;
    push(3'b001, 4'h1, 1'b0, 1'b0); push(3'b010, 4'h2, 1'b0, 1'b0); push(3'b100, 4'h4, 1'b0, 1'b0);
    push(3'b001, 4'h1, 1'b0, 1'b0); push(3'b010, 4'h2, 1'b0, 1'b0); push(3'b100, 4'h4, 1'b1, 1'b0);
    push(3'b001, 4'h8, 1'b1, 1'b1); push(3'b010, 4'h9, 1'b1, 1'b0); push(3'b100, 4'hA, 1'b1, 1'b0);
    push(3'b001, 4'h8, 1'b1, 1'b0); push(3'b010, 4'h9, 1'b1, 1'b0); push(3'b100, 4'hA, 1'b0, 1'b0);
    push(3'b001, 4'h1, 1'b0, 1'b1);
    run_ticks(5);
    cyc(1);
    check("frame_start_width", 32'(frame_start), 32'h0);

    // Pause holds frame 0 across scan wraps.
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push(3'b010, 4'h2, 1'b0, 1'b0); push(3'b100, 4'h4, 1'b0, 1'b0); push(3'b001, 4'h1, 1'b0, 1'b0);
    end
    run_ticks(3);
    pause = 1'b0;
    push(3'b010, 4'h2, 1'b0, 1'b0); push(3'b100, 4'h4, 1'b1, 1'b0); push(3'b001, 4'h8, 1'b1, 1'b1);
    run_ticks(4);

    // Disable mid-row 1, then re-enable.
    push(3'b010, 4'h9, 1'b1, 1'b0);
    run_ticks(4);
    cyc(2);
    en = 1'b0;
    cyc(1);
    check("disable_dot_row", 32'(dot_row), 32'h0);
    check("disable_dot_col", 32'(dot_col), 32'h0);
    check("disable_frame_idx", 32'(frame_idx), 32'h1);
    check("disable_frame_start", 32'(frame_start), 32'h0);
    en = 1'b1;
    push(3'b001, 4'h8, 1'b1, 1'b0);
    run_ticks(5);
    push(3'b010, 4'h9, 1'b1, 1'b0); push(3'b100, 4'hA, 1'b1, 1'b0); push(3'b001, 4'h8, 1'b1, 1'b0);
    push(3'b010, 4'h9, 1'b1, 1'b0); push(3'b100, 4'hA, 1'b0, 1'b0); push(3'b001, 4'h1, 1'b0, 1'b1);
    run_ticks(4);

    // Write f0 row 1 in the same cycle it is read for display.
    push(3'b010, 4'h2, 1'b0, 1'b0);
    cyc(3);
    wr_en = 1'b1; wr_frame = 1'b0; wr_row = 2'd1; wr_data = 4'hF;
    cyc(1);
    wr_en = 1'b0;
    pop_check();
    push(3'b100, 4'h4, 1'b0, 1'b0); push(3'b001, 4'h1, 1'b0, 1'b0); push(3'b010, 4'hF, 1'b0, 1'b0);
    run_ticks(4);

    // last_frame=0 while on frame 0: advance returns to frame 0 with a pulse.
    last_frame = 1'b0;
    push(3'b100, 4'h4, 1'b0, 1'b0); push(3'b001, 4'h1, 1'b0, 1'b1);
    run_ticks(4);
    last_frame = 1'b1;
    push(3'b010, 4'hF, 1'b0, 1'b0); push(3'b100, 4'h4, 1'b0, 1'b0); push(3'b001, 4'h1, 1'b0, 1'b0);
    push(3'b010, 4'hF, 1'b0, 1'b0); push(3'b100, 4'h4, 1'b1, 1'b0); push(3'b001, 4'h8, 1'b1, 1'b1);
    run_ticks(4);

    // Asynchronous reset mid-row.
    cyc(2);
    rst = 1'b1;
    #1;
    check("async_rst_dot_row", 32'(dot_row), 32'h0);
    check("async_rst_dot_col", 32'(dot_col), 32'h0);
    check("async_rst_frame_idx", 32'(frame_idx), 32'h0);
    check("async_rst_frame_start", 32'(frame_start), 32'h0);
    en = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(6);
    check("post_rst_idle", 32'(dot_row), 32'h0);
    check("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
